// File: rtl/sync_timing_monitor_if.sv
// Frontend sync stream and measurement results for sync_timing_monitor.
// Optional IRQ signals exist only when SYNC_MON_IRQ_EN is defined.
interface sync_timing_monitor_if #(
    parameter int unsigned H_W = 11,
    parameter int unsigned V_W = 10,
    parameter int unsigned F_W = 22
);
    logic           hsync;
    logic           vsync;
    logic           de;
    logic [H_W-1:0] h_total;
    logic [H_W-1:0] h_active;
    logic [V_W-1:0] v_total;
    logic [V_W-1:0] v_active;
    logic [F_W-1:0] vclks_per_frame;
    logic           stable;
    logic           mode_change;
    logic           sync_lost;
`ifdef SYNC_MON_IRQ_EN
    logic           irq;
    logic           irq_clr;

    modport master (
        output hsync, vsync, de, irq_clr,
        input  h_total, h_active, v_total, v_active, vclks_per_frame,
        input  stable, mode_change, sync_lost, irq
    );
    modport slave (
        input  hsync, vsync, de, irq_clr,
        output h_total, h_active, v_total, v_active, vclks_per_frame,
        output stable, mode_change, sync_lost, irq
    );
`else
    modport master (
        output hsync, vsync, de,
        input  h_total, h_active, v_total, v_active, vclks_per_frame,
        input  stable, mode_change, sync_lost
    );
    modport slave (
        input  hsync, vsync, de,
        output h_total, h_active, v_total, v_active, vclks_per_frame,
        output stable, mode_change, sync_lost
    );
`endif
endinterface

// File: rtl/sync_timing_monitor.sv
// Measures HSYNC/VSYNC/DE timing per frame and tracks lock to a stable video mode.
// Optional sticky IRQ output is enabled by defining SYNC_MON_IRQ_EN.
module sync_timing_monitor #(
    parameter int unsigned H_W           = 11,
    parameter int unsigned V_W           = 10,
    parameter int unsigned F_W           = 22,
    parameter int unsigned H_TOL         = 2,
    parameter int unsigned STABLE_FRAMES = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    sync_timing_monitor_if.slave mon
);
    localparam int unsigned M_W = $clog2(STABLE_FRAMES + 1);

    typedef enum logic [1:0] {StNoSync, StAcquire, StLocked} state_e;

    state_e         state_q, state_d;
    logic           hs_q, vs_q;
    logic [H_W-1:0] hcnt_q, decnt_q, line_h_q, line_de_q, line_h_d, line_de_d;
    logic [V_W-1:0] line_cnt_q, act_lines_q, line_cnt_d, act_lines_d;
    logic [F_W-1:0] fcnt_q;
    logic [M_W-1:0] match_cnt_q, match_cnt_d;
    logic [H_W-1:0] h_total_q, h_active_q, h_diff;
    logic [V_W-1:0] v_total_q, v_active_q;
    logic [F_W-1:0] vclks_q;
    logic           stable_q, stable_d, mode_change_q, mode_change_d, sync_lost_q, sync_lost_d;
    logic           hs_fall, vs_fall, timeout, match;

    function automatic logic [H_W-1:0] inc_h(input logic [H_W-1:0] x);
        return (x == '1) ? x : x + H_W'(1);
    endfunction
    function automatic logic [V_W-1:0] inc_v(input logic [V_W-1:0] x);
        return (x == '1) ? x : x + V_W'(1);
    endfunction
    function automatic logic [F_W-1:0] inc_f(input logic [F_W-1:0] x);
        return (x == '1) ? x : x + F_W'(1);
    endfunction

    assign hs_fall = hs_q & ~mon.hsync;
    assign vs_fall = vs_q & ~mon.vsync;
    assign timeout = (fcnt_q == '1) & ~vs_fall;

    // Line-close results; a coincident vs_fall latches these, so that line joins this frame.
    always_comb begin
        line_h_d    = line_h_q;
        line_de_d   = line_de_q;
        line_cnt_d  = line_cnt_q;
        act_lines_d = act_lines_q;
        if (hs_fall) begin
            line_h_d   = inc_h(hcnt_q);
            line_cnt_d = inc_v(line_cnt_q);
            if (decnt_q != '0) begin
                line_de_d   = decnt_q;
                act_lines_d = inc_v(act_lines_q);
            end
        end
    end

    assign h_diff = (line_h_d >= h_total_q) ? (line_h_d - h_total_q) : (h_total_q - line_h_d);
    assign match  = (line_cnt_d == v_total_q) && (line_cnt_d != '0) && (h_diff <= H_W'(H_TOL));

    always_comb begin
        state_d       = state_q;
        match_cnt_d   = match_cnt_q;
        stable_d      = stable_q;
        mode_change_d = 1'b0;
        sync_lost_d   = sync_lost_q;
        if (timeout) begin
            state_d     = StNoSync;
            stable_d    = 1'b0;
            sync_lost_d = 1'b1;
        end else if (vs_fall) begin
            case (state_q)
                StNoSync: begin
                    state_d     = StAcquire;
                    match_cnt_d = '0;
                    sync_lost_d = 1'b0;
                end
                StAcquire: begin
                    if (!match) begin
                        match_cnt_d = '0;
                    end else if (match_cnt_q == M_W'(STABLE_FRAMES - 2)) begin
                        state_d       = StLocked;
                        match_cnt_d   = '0;
                        stable_d      = 1'b1;
                        mode_change_d = 1'b1;
                    end else begin
                        match_cnt_d = match_cnt_q + M_W'(1);
                    end
                end
                StLocked: begin
                    if (!match) begin
                        state_d     = StAcquire;
                        match_cnt_d = '0;
                        stable_d    = 1'b0;
                    end
                end
                default: state_d = StNoSync;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StNoSync;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            hcnt_q        <= '0;
            decnt_q       <= '0;
            fcnt_q        <= '0;
            line_h_q      <= '0;
            line_de_q     <= '0;
            line_cnt_q    <= '0;
            act_lines_q   <= '0;
            match_cnt_q   <= '0;
            h_total_q     <= '0;
            h_active_q    <= '0;
            v_total_q     <= '0;
            v_active_q    <= '0;
            vclks_q       <= '0;
            stable_q      <= 1'b0;
            mode_change_q <= 1'b0;
            sync_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= mon.hsync;
            vs_q          <= mon.vsync;
            hcnt_q        <= hs_fall ? '0 : inc_h(hcnt_q);
            decnt_q       <= hs_fall ? '0 : (mon.de ? inc_h(decnt_q) : decnt_q);
            fcnt_q        <= vs_fall ? '0 : inc_f(fcnt_q);
            line_h_q      <= line_h_d;
            line_de_q     <= line_de_d;
            line_cnt_q    <= vs_fall ? '0 : line_cnt_d;
            act_lines_q   <= vs_fall ? '0 : act_lines_d;
            match_cnt_q   <= match_cnt_d;
            stable_q      <= stable_d;
            mode_change_q <= mode_change_d;
            sync_lost_q   <= sync_lost_d;
            if (vs_fall) begin
                h_total_q  <= line_h_d;
                h_active_q <= line_de_d;
                v_total_q  <= line_cnt_d;
                v_active_q <= act_lines_d;
                vclks_q    <= inc_f(fcnt_q);
            end
        end
    end

    assign mon.h_total         = h_total_q;
    assign mon.h_active        = h_active_q;
    assign mon.v_total         = v_total_q;
    assign mon.v_active        = v_active_q;
    assign mon.vclks_per_frame = vclks_q;
    assign mon.stable          = stable_q;
    assign mon.mode_change     = mode_change_q;
    assign mon.sync_lost       = sync_lost_q;

`ifdef SYNC_MON_IRQ_EN
    logic irq_q, sync_lost_prev_q;

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q            <= 1'b0;
            sync_lost_prev_q <= 1'b0;
        end else begin
            sync_lost_prev_q <= sync_lost_q;
            if (mode_change_q || (sync_lost_q && !sync_lost_prev_q)) begin
                irq_q <= 1'b1;
            end else if (mon.irq_clr) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign mon.irq = irq_q;
`endif
endmodule

// File: tb/tb_sync_timing_monitor.sv
// Directed bench for sync_timing_monitor on a scaled 64-clock x 20-line raster
// with a 12-bit frame counter so the VSYNC timeout is reachable quickly.
module tb_sync_timing_monitor;
    localparam int unsigned H_W    = 11;
    localparam int unsigned V_W    = 10;
    localparam int unsigned F_W    = 12;
    localparam int unsigned H_TOL  = 2;
    localparam int unsigned STABLE = 4;
    localparam int HMAX = (1 << H_W) - 1;
    localparam int VMAX = (1 << V_W) - 1;
    localparam int FMAX = (1 << F_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   mc_count = 0;

    sync_timing_monitor_if #(.H_W(H_W), .V_W(V_W), .F_W(F_W)) bus ();

    sync_timing_monitor #(
        .H_W          (H_W),
        .V_W          (V_W),
        .F_W          (F_W),
        .H_TOL        (H_TOL),
        .STABLE_FRAMES(STABLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .mon  (bus)
    );

    always #5 clk = ~clk;

    // Timestamp model: cycle index c counts active edges since reset release.
    int c, last_hs, last_vs, prev_h, prev_v, de_cnt, m_line_h, m_line_de, lines, act;
    int o_h, o_ha, o_v, o_va, o_f, streak;
    bit tracking, m_stable, m_mc, m_sl, m_irq, m_sl_prev;

    task automatic model_reset();
        c = 0; last_hs = -1; last_vs = -1; prev_h = 0; prev_v = 0; de_cnt = 0;
        m_line_h = 0; m_line_de = 0; lines = 0; act = 0;
        o_h = 0; o_ha = 0; o_v = 0; o_va = 0; o_f = 0; streak = 0;
        tracking = 0; m_stable = 0; m_mc = 0; m_sl = 0; m_irq = 0; m_sl_prev = 0;
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step();
        bit hsf, vsf, good, clr;
        int fc_before, dh;
        hsf = (prev_h == 1) && !bus.hsync;
        vsf = (prev_v == 1) && !bus.vsync;
        fc_before = min2(c - last_vs - 1, FMAX);
`ifdef SYNC_MON_IRQ_EN
        clr = bus.irq_clr;
`else
        clr = 1'b0;
`endif
        if (m_mc || (m_sl && !m_sl_prev)) m_irq = 1'b1;
        else if (clr) m_irq = 1'b0;
        m_sl_prev = m_sl;
        m_mc = 1'b0;
        if (hsf) begin
            m_line_h = min2(c - last_hs, HMAX);
            if (de_cnt != 0) begin
                m_line_de = de_cnt;
                act = min2(act + 1, VMAX);
            end
            lines = min2(lines + 1, VMAX);
            last_hs = c;
            de_cnt = 0;
        end else if (bus.de) begin
            de_cnt = min2(de_cnt + 1, HMAX);
        end
        if (vsf) begin
            dh = m_line_h - o_h;
            if (dh < 0) dh = -dh;
            good = (lines != 0) && (lines == o_v) && (dh <= int'(H_TOL));
            o_h = m_line_h; o_ha = m_line_de; o_v = lines; o_va = act;
            o_f = min2(c - last_vs, FMAX);
            last_vs = c;
            lines = 0; act = 0;
            if (!tracking) begin
                tracking = 1'b1; streak = 0; m_sl = 1'b0;
            end else if (!good) begin
                streak = 0; m_stable = 1'b0;
            end else if (!m_stable) begin
                streak++;
                if (streak == int'(STABLE) - 1) begin
                    m_stable = 1'b1; m_mc = 1'b1; streak = 0;
                end
            end
        end else if (fc_before >= FMAX) begin
            tracking = 1'b0; m_stable = 1'b0; m_sl = 1'b1;
        end
        prev_h = int'(bus.hsync);
        prev_v = int'(bus.vsync);
        c++;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                n_checks++;
                if (bus.h_total !== H_W'(o_h) || bus.h_active !== H_W'(o_ha) ||
                    bus.v_total !== V_W'(o_v) || bus.v_active !== V_W'(o_va) ||
                    bus.vclks_per_frame !== F_W'(o_f) || bus.stable !== m_stable ||
                    bus.mode_change !== m_mc || bus.sync_lost !== m_sl) begin
                    n_errors++;
                    $display("FAIL model_compare t=%0t got h=%0d ha=%0d v=%0d va=%0d f=%0d st=%b mc=%b sl=%b want h=%0d ha=%0d v=%0d va=%0d f=%0d st=%b mc=%b sl=%b",
                             $time, bus.h_total, bus.h_active, bus.v_total, bus.v_active,
                             bus.vclks_per_frame, bus.stable, bus.mode_change, bus.sync_lost,
                             o_h, o_ha, o_v, o_va, o_f, m_stable, m_mc, m_sl);
                end
`ifdef SYNC_MON_IRQ_EN
                n_checks++;
                if (bus.irq !== m_irq) begin
                    n_errors++;
                    $display("FAIL irq_compare t=%0t got %b want %b", $time, bus.irq, m_irq);
                end
`endif
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.mode_change === 1'b1) mc_count++;
        end
    end

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", name, act_v, exp_v);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_h_total"}, 32'(bus.h_total), 0);
        check({tag, "_h_active"}, 32'(bus.h_active), 0);
        check({tag, "_v_total"}, 32'(bus.v_total), 0);
        check({tag, "_v_active"}, 32'(bus.v_active), 0);
        check({tag, "_vclks"}, 32'(bus.vclks_per_frame), 0);
        check({tag, "_stable"}, 32'(bus.stable), 0);
        check({tag, "_mode_change"}, 32'(bus.mode_change), 0);
        check({tag, "_sync_lost"}, 32'(bus.sync_lost), 0);
    endtask

    // Sync pulses occupy the last 6 clocks of a line; VSYNC falls with the last line's HSYNC.
    task automatic run_line(input int len, input bit de_line, input bit vs_line);
        for (int i = 0; i < len; i++) begin
            bus.hsync = !(i >= len - 6);
            bus.vsync = !(vs_line && i >= len - 6);
            bus.de    = de_line && i >= 8 && i < 48;
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input int len, input int nlines, input bit vs_en);
        for (int l = 0; l < nlines; l++) begin
            run_line(len, l >= 4 && l <= 15, vs_en && l == nlines - 1);
        end
    endtask

    initial begin
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        bus.de    = 1'b0;
`ifdef SYNC_MON_IRQ_EN
        bus.irq_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Steady raster: lock on the 4th VSYNC fall.
        repeat (3) run_frame(64, 20, 1'b1);
        check("pre_lock_stable", 32'(bus.stable), 0);
        run_frame(64, 20, 1'b1);
        check("lock_h_total", 32'(bus.h_total), 64);
        check("lock_h_active", 32'(bus.h_active), 40);
        check("lock_v_total_coincident", 32'(bus.v_total), 20);
        check("lock_v_active", 32'(bus.v_active), 12);
        check("lock_vclks", 32'(bus.vclks_per_frame), 1280);
        check("lock_stable", 32'(bus.stable), 1);
        check("lock_mc_count", 32'(mc_count), 1);
`ifdef SYNC_MON_IRQ_EN
        check("irq_on_lock", 32'(bus.irq), 1);
        bus.irq_clr = 1'b1;
        @(negedge clk);
        bus.irq_clr = 1'b0;
        check("irq_cleared", 32'(bus.irq), 0);
`endif

        // Line-length jitter within tolerance keeps lock.
        run_frame(63, 20, 1'b1);
        run_frame(65, 20, 1'b1);
        run_frame(63, 20, 1'b1);
        run_frame(65, 20, 1'b1);
        check("jitter_stable", 32'(bus.stable), 1);
        check("jitter_h_total", 32'(bus.h_total), 65);
        check("jitter_vclks", 32'(bus.vclks_per_frame), 1300);
        check("jitter_mc_count", 32'(mc_count), 1);

        // Out-of-tolerance line drops lock; relock after four good frames.
        run_frame(68, 20, 1'b1);
        check("bad_h_stable", 32'(bus.stable), 0);
        repeat (3) run_frame(64, 20, 1'b1);
        check("relock_pending", 32'(bus.stable), 0);
        run_frame(64, 20, 1'b1);
        check("relock_stable", 32'(bus.stable), 1);
        check("relock_mc_count", 32'(mc_count), 2);

        // Line count change.
        run_frame(64, 21, 1'b1);
        check("vchange_stable", 32'(bus.stable), 0);
        check("vchange_v_total", 32'(bus.v_total), 21);
        repeat (3) run_frame(64, 21, 1'b1);
        check("vchange_relock", 32'(bus.stable), 1);
        check("vchange_mc_count", 32'(mc_count), 3);

        // VSYNC stops long enough to saturate the frame counter.
        run_frame(64, 70, 1'b0);
        check("timeout_sync_lost", 32'(bus.sync_lost), 1);
        check("timeout_stable", 32'(bus.stable), 0);
        check("timeout_hold_v_total", 32'(bus.v_total), 21);
        check("timeout_hold_vclks", 32'(bus.vclks_per_frame), 1344);
        run_frame(64, 20, 1'b1);
        check("resume_sync_lost", 32'(bus.sync_lost), 0);
        check("resume_v_total", 32'(bus.v_total), 90);
        check("resume_v_active", 32'(bus.v_active), 24);
        check("resume_vclks_sat", 32'(bus.vclks_per_frame), FMAX);
        repeat (4) run_frame(64, 20, 1'b1);
        check("resume_lock", 32'(bus.stable), 1);
        check("resume_mc_count", 32'(mc_count), 4);

        // Reset mid-frame.
        run_frame(64, 10, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("midreset");
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        bus.de    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) run_frame(64, 20, 1'b1);
        check("post_reset_pending", 32'(bus.stable), 0);
        run_frame(64, 20, 1'b1);
        check("post_reset_lock", 32'(bus.stable), 1);
        check("post_reset_v_total", 32'(bus.v_total), 20);
        check("post_reset_mc_count", 32'(mc_count), 5);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
